// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: types and helpers shared by the CPU and its load/store unit.
//   mips_op_e    - MIPS load/store primary opcodes (bits [31:26] of the instruction)
//   lsu_state_e  - LSU sequencing states
//   lsu_is_store - true for SB/SH/SW
//   lsu_op_error - true when an op must be answered with an address error
// Build option: MIPS_LSU_UNALIGNED_EN enables LWL/LWR; when it is undefined
// those two opcodes are rejected like any other unknown opcode.
package mips_cpu_pkg;

    typedef enum logic [5:0] {
        OP_LB  = 6'h20,
        OP_LH  = 6'h21,
        OP_LWL = 6'h22,
        OP_LW  = 6'h23,
        OP_LBU = 6'h24,
        OP_LHU = 6'h25,
        OP_LWR = 6'h26,
        OP_SB  = 6'h28,
        OP_SH  = 6'h29,
        OP_SW  = 6'h2B
    } mips_op_e;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic lsu_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Misaligned halfword/word accesses and unknown opcodes never reach the bus.
    function automatic logic lsu_op_error(input logic [5:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1'b0;
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            OP_LW, OP_SW:         return |addr_lo;
`ifdef MIPS_LSU_UNALIGNED_EN
            OP_LWL, OP_LWR:       return 1'b0;
`endif
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// mips_cpu_lsu_align: purely combinational lane logic for the LSU.
//   op_i         - registered opcode
//   addr_lo_i    - registered address bits [1:0]
//   wdata_i      - registered store data / old rt value
//   rdata_i      - word returned by memory
//   byteenable_o - active byte lanes (little-endian)
//   writedata_o  - store data replicated onto the lanes
//   load_data_o  - extended / merged load result
// Build option: MIPS_LSU_UNALIGNED_EN adds the LWL/LWR merge paths.
module mips_cpu_lsu_align
    import mips_cpu_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byteenable_o,
    output logic [31:0] writedata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  rd_byte [4];
    logic [7:0]  lane_wd [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Replicating SB/SH data onto every lane lets memory pick it up wherever
    // byteenable points, without a barrel shifter on the store path.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = rdata_i[8*gi +: 8];
        assign lane_wd[gi] = (op_i == OP_SB) ? wdata_i[7:0] :
                             (op_i == OP_SH) ? wdata_i[8*(gi%2) +: 8] :
                                               wdata_i[8*gi +: 8];
        assign writedata_o[8*gi +: 8] = lane_wd[gi];
    end

`ifdef MIPS_LSU_UNALIGNED_EN
    logic [4:0] lwl_sh;
    logic [4:0] lwr_sh;
    // LWL moves the low addr+1 memory bytes to the top of rt; LWR moves the
    // bytes from addr upward to the bottom of rt.
    assign lwl_sh = {~addr_lo_i, 3'b000};
    assign lwr_sh = {addr_lo_i, 3'b000};
`endif

    always_comb begin
        sel_byte     = rd_byte[addr_lo_i];
        sel_half     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        byteenable_o = 4'b1111;
        load_data_o  = rdata_i;

        case (op_i)
            OP_LB, OP_LBU, OP_SB: byteenable_o = 4'b0001 << addr_lo_i;
            OP_LH, OP_LHU, OP_SH: byteenable_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            default:              byteenable_o = 4'b1111;
        endcase

        case (op_i)
            OP_LB:   load_data_o = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data_o = {24'b0, sel_byte};
            OP_LH:   load_data_o = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_data_o = {16'b0, sel_half};
`ifdef MIPS_LSU_UNALIGNED_EN
            OP_LWL:  load_data_o = (rdata_i << lwl_sh) | (wdata_i & ~(32'hFFFF_FFFF << lwl_sh));
            OP_LWR:  load_data_o = (rdata_i >> lwr_sh) | (wdata_i & ~(32'hFFFF_FFFF >> lwr_sh));
`endif
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu: load/store unit between the MIPS core and a word-wide
// Avalon-style memory port with waitrequest.
//   clk, rst             - clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake (ready only while idle)
//   req_op/addr/wdata    - opcode, byte address, store data or old rt
//   resp_valid           - one-cycle completion pulse
//   resp_rdata/resp_err  - load result (0 for stores) and address error
//   mem_*                - word-aligned memory strobes, lanes and data
// Build option: MIPS_LSU_UNALIGNED_EN enables LWL/LWR.
module mips_cpu_lsu
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    lsu_state_e  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept_err;
    logic        store_q;
    logic [3:0]  align_be;
    logic [31:0] align_wd;
    logic [31:0] align_load;

    assign accept_err = lsu_op_error(req_op, req_addr[1:0]);
    assign store_q    = lsu_is_store(op_q);

    mips_cpu_lsu_align u_align (
        .op_i         (op_q),
        .addr_lo_i    (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .rdata_i      (mem_readdata),
        .byteenable_o (align_be),
        .writedata_o  (align_wd),
        .load_data_o  (align_load)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = 32'b0;
        resp_err       = 1'b0;
        mem_address    = 32'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'b0;
        mem_writedata  = 32'b0;

        case (state_q)
            LSU_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = accept_err;
                    rdata_d = 32'b0;
                    // Faulting requests skip the bus and answer immediately.
                    state_d = accept_err ? LSU_RESP : LSU_ACCESS;
                end
            end
            LSU_ACCESS: begin
                // All bus outputs come from registers, so they stay put
                // for as long as memory stalls.
                mem_read       = ~store_q;
                mem_write      = store_q;
                mem_address    = {addr_q[31:2], 2'b00};
                mem_byteenable = align_be;
                mem_writedata  = store_q ? align_wd : 32'b0;
                if (!mem_waitrequest) begin
                    rdata_d = store_q ? 32'b0 : align_load;
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            op_q    <= 6'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb_mips_cpu_lsu: self-checking bench for mips_cpu_lsu. Directed vectors
// followed by randomized requests checked against a byte-level reference
// model. Build option: MIPS_LSU_UNALIGNED_EN selects the LWL/LWR model.
module tb_mips_cpu_lsu;

    localparam logic [5:0] LB  = 6'h20, LH  = 6'h21, LWL = 6'h22, LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24, LHU = 6'h25, LWR = 6'h26;
    localparam logic [5:0] SB  = 6'h28, SH  = 6'h29, SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = 6'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = 32'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  obs_be;
    logic [31:0] obs_wd;
    logic [31:0] obs_rd;
    logic        obs_err;

    mips_cpu_lsu dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_is_store(input logic [5:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic m_err(input logic [5:0] op, input logic [1:0] a);
        if (op == LB || op == LBU || op == SB) return 1'b0;
        if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
        if (op == LW || op == SW)              return a != 0;
`ifdef MIPS_LSU_UNALIGNED_EN
        if (op == LWL || op == LWR)            return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_be(input logic [5:0] op, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0;
        if (op == LB || op == LBU || op == SB) be[a] = 1'b1;
        else if (op == LH || op == LHU || op == SH) be = (a >= 2) ? 4'b1100 : 4'b0011;
        else be = 4'b1111;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] w);
        if (op == SB) return {4{w[7:0]}};
        if (op == SH) return {2{w[15:0]}};
        return w;
    endfunction

    function automatic logic [31:0] m_rd(input logic [5:0] op, input logic [1:0] a,
                                         input logic [31:0] rt, input logic [31:0] mem);
        logic [31:0] b, h, r;
        int ai;
        ai = int'(a);
        b  = (mem >> (8 * ai)) & 32'hFF;
        h  = (mem >> ((ai >= 2) ? 16 : 0)) & 32'hFFFF;
        r  = rt;
        if (m_err(op, a) || m_is_store(op)) return 32'b0;
        case (op)
            LB:  return (b < 128) ? b : b + 32'hFFFF_FF00;
            LBU: return b;
            LH:  return (h < 32768) ? h : h + 32'hFFFF_0000;
            LHU: return h;
            LWL: begin
                for (int i = 0; i <= ai; i++) r[8*(3-i) +: 8] = mem[8*(ai-i) +: 8];
                return r;
            end
            LWR: begin
                for (int i = 0; i <= 3 - ai; i++) r[8*i +: 8] = mem[8*(ai+i) +: 8];
                return r;
            end
            default: return mem;
        endcase
    endfunction

    // One request from acceptance to the idle cycle after its response.
    // Called at a negedge while the DUT is idle; nwait = stall cycles.
    task automatic do_txn(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int nwait);
        logic e, st;
        e  = m_err(op, addr[1:0]);
        st = m_is_store(op);
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        mem_waitrequest = 1'b0;
        @(negedge clk);
        // Garbage on the request port while busy must be ignored.
        req_valid = 1'($urandom); req_op = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
        obs_be = 4'b0; obs_wd = 32'b0;
        if (!e) begin
            for (int k = 0; k <= nwait; k++) begin
                chk("ready_busy", req_ready, 0);
                chk("resp_early", resp_valid, 0);
                chk("mem_read", mem_read, !st);
                chk("mem_write", mem_write, st);
                chk("mem_address", mem_address, {addr[31:2], 2'b00});
                chk("byteenable", mem_byteenable, m_be(op, addr[1:0]));
                if (st) chk("writedata", mem_writedata, m_wd(op, wd));
                if (k == 0) begin obs_be = mem_byteenable; obs_wd = mem_writedata; end
                mem_waitrequest = (k < nwait);
                mem_readdata    = (k < nwait) ? $urandom : rd;
                @(negedge clk);
                req_valid = 1'($urandom); req_op = 6'($urandom); req_addr = $urandom;
            end
        end
        mem_waitrequest = 1'b0;
        obs_rd  = resp_rdata;
        obs_err = resp_err;
        chk("resp_valid", resp_valid, 1);
        chk("resp_err", resp_err, e);
        chk("resp_rdata", resp_rdata, m_rd(op, addr[1:0], wd, rd));
        chk("bus_quiet_resp", {mem_read, mem_write}, 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("resp_pulse", resp_valid, 0);
        $display("[TB] txn op=%h addr=%h wdata=%h rdata=%h wait=%0d -> resp=%h err=%0b",
                 op, addr, wd, rd, nwait, obs_rd, obs_err);
    endtask

    logic [5:0] ops [10] = '{LB, LH, LWL, LW, LBU, LHU, LWR, SB, SH, SW};

    initial begin
        logic [5:0] rop;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp", {resp_valid, resp_err}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_strobes", {mem_read, mem_write, mem_byteenable}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_writedata, 0);
        rst = 1'b0;
        @(negedge clk);

        // SB to top lane
        do_txn(SB, 32'h1003, 32'h0000_00AB, $urandom, 0);
        chk("sb_be", obs_be, 4'b1000);
        chk("sb_wd", obs_wd, 32'hABAB_ABAB);
        chk("sb_err", obs_err, 0);
        // LB sign extension
        do_txn(LB, 32'h2001, 32'h0, 32'h0000_8000, 0);
        chk("lb_rdata", obs_rd, 32'hFFFF_FF80);
        // LW with 3 stall cycles
        do_txn(LW, 32'h2000, 32'h0, 32'h1234_5678, 3);
        chk("lw_rdata", obs_rd, 32'h1234_5678);
        // misaligned SW
        do_txn(SW, 32'h2002, 32'h55, 32'h0, 0);
        chk("sw_mis_err", obs_err, 1);
        // halfword boundaries
        do_txn(LH, 32'h4003, 32'h0, 32'hFFFF_FFFF, 0);
        chk("lh_mis_err", obs_err, 1);
        do_txn(LHU, 32'h4002, 32'h0, 32'h8001_0000, 1);
        chk("lhu_rdata", obs_rd, 32'h0000_8001);
        do_txn(SH, 32'h4002, 32'h1234_BEEF, 32'h0, 2);
        chk("sh_be", obs_be, 4'b1100);
        chk("sh_wd", obs_wd, 32'hBEEF_BEEF);
        // unknown opcode
        do_txn(6'h3F, 32'h0, 32'h0, 32'h0, 0);
        chk("bad_op_err", obs_err, 1);
`ifdef MIPS_LSU_UNALIGNED_EN
        do_txn(LWL, 32'h1001, 32'hAABB_CCDD, 32'h4433_2211, 0);
        chk("lwl_rdata", obs_rd, 32'h2211_CCDD);
        do_txn(LWR, 32'h1001, 32'hAABB_CCDD, 32'h4433_2211, 1);
        chk("lwr_rdata", obs_rd, 32'hAA44_3322);
`else
        do_txn(LWL, 32'h1001, 32'hAABB_CCDD, 32'h4433_2211, 0);
        chk("lwl_off_err", obs_err, 1);
`endif

        // reset in the middle of an access
        chk("ready_pre_rst", req_ready, 1);
        req_valid = 1'b1; req_op = LW; req_addr = 32'h3000; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_read", mem_read, 1);
        mem_waitrequest = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_waitrequest = 1'b0;
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_read0", mem_read, 0);
        chk("rst_mid_bus", {mem_write, mem_byteenable, mem_address}, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_noresp", resp_valid, 0);
            @(negedge clk);
        end
        $display("[TB] txn reset during access -> no response");

        // randomized requests
        for (int n = 0; n < 60; n++) begin
            rop = ($urandom_range(0, 10) == 10) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            do_txn(rop, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
